aes_round_ctrl: RTL and testbench



---
 rtl/aes_ctrl_pkg.sv | 20 ++
 rtl/aes_round_cnt.sv | 28 ++
 rtl/aes_round_ctrl.sv | 149 ++++++++++++++
 tb/tb_aes_round_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES round sequencing controller.
// legal_nr() lets the top reject unsupported round counts at elaboration.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    function automatic bit legal_nr(input int nr);
        return (nr == NR_128) || (nr == NR_192) || (nr == NR_256);
    endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Round index register: clear, increment or hold, plus a flag marking the
// final cipher round (index equal to NR).
module aes_round_cnt #(
    parameter int NR      = 10,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_inc,
    output logic [ROUND_W-1:0] o_idx,
    output logic               o_is_last
);

    logic [ROUND_W-1:0] r_idx;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_idx     = r_idx;
    assign o_is_last = (r_idx == ROUND_W'(NR));

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencing controller for the AES cipher datapath: block load, initial
// AddRoundKey, NR rounds gated by key availability, then output handshake.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// in_valid/in_ready load a block (only in IDLE); out_valid/out_ready retire
// the result (only in DONE). out_valid holds until the transfer or an abort.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NR      = 10,
    parameter int ROUND_W = 4,
    parameter int STALL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               text_ld_en,
    input  logic               abort,
    input  logic               key_valid,
    output logic               kexp_adv,
    output logic               sa_en,
    output logic               first_round,
    output logic               final_round,
    output logic [ROUND_W-1:0] round_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic [STALL_W-1:0] stall_cnt,
    output state_t             dbg_state
);

    if (!legal_nr(NR)) begin : g_bad_nr
        $error("aes_round_ctrl: NR must be 10, 12 or 14");
    end
    if ((1 << ROUND_W) <= NR) begin : g_bad_round_w
        $error("aes_round_ctrl: ROUND_W too narrow for NR");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [STALL_W-1:0] r_stall;
    logic [STALL_W-1:0] w_stall_nxt;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_is_last;
    logic [ROUND_W-1:0] w_idx;

    aes_round_cnt #(
        .NR      (NR),
        .ROUND_W (ROUND_W)
    ) u_round_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_cnt_clr),
        .i_inc     (w_cnt_inc),
        .o_idx     (w_idx),
        .o_is_last (w_is_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stall <= w_stall_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall_nxt = r_stall;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        in_ready    = 1'b0;
        text_ld_en  = 1'b0;
        sa_en       = 1'b0;
        kexp_adv    = 1'b0;
        first_round = 1'b0;
        final_round = 1'b0;
        out_valid   = 1'b0;

        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    text_ld_en  = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_stall_nxt = '0;
                    w_state_nxt = INIT;
                end
            end
            INIT: begin
                first_round = 1'b1;
                if (abort) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    sa_en       = 1'b1;
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = ROUND;
                end
            end
            ROUND: begin
                final_round = w_is_last;
                if (abort) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (key_valid) begin
                    sa_en    = 1'b1;
                    kexp_adv = 1'b1;
                    if (w_is_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end else begin
                    w_stall_nxt = (&r_stall) ? r_stall : r_stall + 1'b1;
                end
            end
            DONE: begin
                // An abort retires the block silently, so no transfer may be seen.
                out_valid = !abort;
                if (abort) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (rst) begin
            in_ready   = 1'b0;
            text_ld_en = 1'b0;
            sa_en      = 1'b0;
            kexp_adv   = 1'b0;
            out_valid  = 1'b0;
        end
    end

    assign round_idx = w_idx;
    assign busy      = (r_state != IDLE);
    assign stall_cnt = r_stall;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: NR=10 and NR=14 instances share stimulus; a
// cycle table plus directed and random blocks checked against a block model.
module tb_aes_round_ctrl;
    import aes_ctrl_pkg::*;

    logic clk;
    logic rst;
    logic in_valid;
    logic abort;
    logic key_valid;
    logic out_ready;

    logic       a_in_ready, a_ld, a_kx, a_sa, a_first, a_final, a_ov, a_busy;
    logic [3:0] a_idx;
    logic [7:0] a_stall;
    state_t     a_state;
    logic       b_in_ready, b_ld, b_kx, b_sa, b_first, b_final, b_ov, b_busy;
    logic [3:0] b_idx;
    logic [7:0] b_stall;
    state_t     b_state;

    aes_round_ctrl #(.NR(10), .ROUND_W(4), .STALL_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .text_ld_en(a_ld), .abort(abort), .key_valid(key_valid),
        .kexp_adv(a_kx), .sa_en(a_sa), .first_round(a_first),
        .final_round(a_final), .round_idx(a_idx), .out_valid(a_ov),
        .out_ready(out_ready), .busy(a_busy), .stall_cnt(a_stall),
        .dbg_state(a_state)
    );

    aes_round_ctrl #(.NR(14), .ROUND_W(4), .STALL_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .text_ld_en(b_ld), .abort(abort), .key_valid(key_valid),
        .kexp_adv(b_kx), .sa_en(b_sa), .first_round(b_first),
        .final_round(b_final), .round_idx(b_idx), .out_valid(b_ov),
        .out_ready(out_ready), .busy(b_busy), .stall_cnt(b_stall),
        .dbg_state(b_state)
    );

    // Observation mux: 0 selects the NR=10 instance, 1 the NR=14 instance.
    logic       tb_sel;
    logic       obs_in_ready, obs_ld, obs_kx, obs_sa, obs_first, obs_final, obs_ov, obs_busy;
    logic [3:0] obs_idx;
    logic [7:0] obs_stall;

    always_comb begin
        obs_in_ready = tb_sel ? b_in_ready : a_in_ready;
        obs_ld       = tb_sel ? b_ld       : a_ld;
        obs_kx       = tb_sel ? b_kx       : a_kx;
        obs_sa       = tb_sel ? b_sa       : a_sa;
        obs_first    = tb_sel ? b_first    : a_first;
        obs_final    = tb_sel ? b_final    : a_final;
        obs_ov       = tb_sel ? b_ov       : a_ov;
        obs_busy     = tb_sel ? b_busy     : a_busy;
        obs_idx      = tb_sel ? b_idx      : a_idx;
        obs_stall    = tb_sel ? b_stall    : a_stall;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // key_valid pattern indexed by cycle since the load; past the end, 1.
    bit kv_q[$];

    function automatic bit kv_at(input int c);
        return (c < kv_q.size()) ? kv_q[c] : 1'b1;
    endfunction

    // Block-level model: rounds run from cycle 2 and each consumes one cycle
    // with key_valid high; the result appears the cycle after the NR-th one.
    function automatic void model(input int nr, output int done_c, output int stalls);
        int ones  = 0;
        int zeros = 0;
        int c     = 2;
        while (ones < nr) begin
            if (kv_at(c)) ones++;
            else zeros++;
            c++;
        end
        done_c = c;
        stalls = (zeros > 255) ? 255 : zeros;
    endfunction

    task automatic sync_idle();
        in_valid = 0; key_valid = 0; out_ready = 0; abort = 1;
        @(posedge clk); #1;
        abort = 0;
        @(posedge clk); #1;
    endtask

    task automatic run_block(input int ordy_delay, output int done_c, output int n_sa,
                             output int n_kx, output int stall_at_done);
        int  ones;
        bit  hs;
        bit  finished;
        done_c = -1; n_sa = 0; n_kx = 0; stall_at_done = -1; ones = 0; finished = 0;
        for (int c = 0; c < 1000; c++) begin
            in_valid  = (c == 0);
            key_valid = kv_at(c);
            out_ready = (done_c >= 0) && (c >= done_c + ordy_delay);
            @(negedge clk);
            if (obs_sa) n_sa++;
            if (obs_kx) n_kx++;
            if (obs_ov && done_c < 0) begin
                done_c        = c;
                stall_at_done = obs_stall;
            end
            if (c >= 2 && done_c < 0 && !key_valid) begin
                chk("stall_idx_hold", obs_idx, 1 + ones);
                chk("stall_sa_off", obs_sa, 0);
            end
            if (c >= 2 && done_c < 0 && key_valid) ones++;
            if (done_c >= 0 && !out_ready) begin
                chk("done_ov_held", obs_ov, 1);
                chk("done_in_ready_low", obs_in_ready, 0);
            end
            hs = obs_ov && out_ready;
            @(posedge clk); #1;
            if (hs) begin
                finished = 1;
                break;
            end
        end
        in_valid = 0; key_valid = 0; out_ready = 0;
        chk("block_completed", finished, 1);
        if (finished) begin
            @(negedge clk);
            chk("back_idle_busy", obs_busy, 0);
            chk("back_idle_in_ready", obs_in_ready, 1);
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic in_valid, key_valid, out_ready;
        logic e_in_ready, e_ld, e_sa, e_kx, e_first, e_final, e_ov, e_busy;
        int   e_idx;
    } vec_t;

    vec_t vt[15];

    initial begin
        int done_c, n_sa, n_kx, st, exp_done, exp_st, nr, dly, p;

        for (int c = 0; c < 15; c++) begin
            vt[c].in_valid   = (c == 0);
            vt[c].key_valid  = 1'b1;
            vt[c].out_ready  = (c == 13);
            vt[c].e_in_ready = (c == 0) || (c == 14);
            vt[c].e_ld       = (c == 0);
            vt[c].e_sa       = (c >= 1 && c <= 11);
            vt[c].e_kx       = (c >= 2 && c <= 11);
            vt[c].e_first    = (c == 1);
            vt[c].e_final    = (c == 11);
            vt[c].e_ov       = (c == 12 || c == 13);
            vt[c].e_busy     = (c >= 1 && c <= 13);
            vt[c].e_idx      = (c <= 1) ? 0 : (c <= 11) ? c - 1 : (c <= 13) ? 10 : -1;
        end

        tb_sel = 0;
        rst = 1; in_valid = 1; key_valid = 1; out_ready = 1; abort = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_ready", obs_in_ready, 0);
        chk("rst_ld", obs_ld, 0);
        chk("rst_ov", obs_ov, 0);
        @(posedge clk); #1;
        rst = 0; in_valid = 0; key_valid = 0; out_ready = 0;
        @(negedge clk);
        chk("reset_busy", obs_busy, 0);
        chk("reset_idx", obs_idx, 0);
        chk("reset_stall", obs_stall, 0);
        chk("reset_in_ready", obs_in_ready, 1);
        @(posedge clk); #1;

        // Cycle table: one unstalled NR=10 block.
        n_sa = 0; n_kx = 0;
        for (int c = 0; c < 15; c++) begin
            in_valid = vt[c].in_valid; key_valid = vt[c].key_valid; out_ready = vt[c].out_ready;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", c), obs_in_ready, vt[c].e_in_ready);
            chk($sformatf("tbl%0d_ld", c), obs_ld, vt[c].e_ld);
            chk($sformatf("tbl%0d_sa", c), obs_sa, vt[c].e_sa);
            chk($sformatf("tbl%0d_kx", c), obs_kx, vt[c].e_kx);
            chk($sformatf("tbl%0d_first", c), obs_first, vt[c].e_first);
            chk($sformatf("tbl%0d_final", c), obs_final, vt[c].e_final);
            chk($sformatf("tbl%0d_ov", c), obs_ov, vt[c].e_ov);
            chk($sformatf("tbl%0d_busy", c), obs_busy, vt[c].e_busy);
            if (vt[c].e_idx >= 0) chk($sformatf("tbl%0d_idx", c), obs_idx, vt[c].e_idx);
            if (obs_sa) n_sa++;
            if (obs_kx) n_kx++;
            @(posedge clk); #1;
        end
        chk("tbl_sa_pulses", n_sa, 11);
        chk("tbl_kx_pulses", n_kx, 10);
        sync_idle();

        // Three-cycle key stall during round 4.
        kv_q.delete();
        for (int i = 0; i < 8; i++) kv_q.push_back(!(i >= 5 && i <= 7));
        run_block(1, done_c, n_sa, n_kx, st);
        model(10, exp_done, exp_st);
        chk("stall3_done", done_c, exp_done);
        chk("stall3_done_const", done_c, 15);
        chk("stall3_cnt", st, 3);
        chk("stall3_sa", n_sa, 11);
        sync_idle();

        // out_ready held low for 5 cycles in DONE.
        kv_q.delete();
        run_block(5, done_c, n_sa, n_kx, st);
        chk("ordy_done", done_c, 12);
        sync_idle();

        // Abort at round 6, then immediate reload.
        for (int c = 0; c < 7; c++) begin
            in_valid = (c == 0); key_valid = 1;
            @(posedge clk); #1;
        end
        in_valid = 0; abort = 1;
        @(negedge clk);
        chk("abort_idx6", obs_idx, 6);
        chk("abort_sa_off", obs_sa, 0);
        chk("abort_kx_off", obs_kx, 0);
        @(posedge clk); #1;
        abort = 0; in_valid = 1;
        @(negedge clk);
        chk("abort_busy", obs_busy, 0);
        chk("abort_idx0", obs_idx, 0);
        chk("abort_ov", obs_ov, 0);
        chk("abort_reload_ld", obs_ld, 1);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk("reload_first", obs_first, 1);
        chk("reload_idx", obs_idx, 0);
        chk("reload_busy", obs_busy, 1);
        @(posedge clk); #1;
        sync_idle();

        // Reset mid-ROUND forces the handshake/enable outputs low.
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 0); key_valid = 1;
            @(posedge clk); #1;
        end
        rst = 1; in_valid = 1; key_valid = 1; out_ready = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rstmid_in_ready", obs_in_ready, 0);
            chk("rstmid_ld", obs_ld, 0);
            chk("rstmid_sa", obs_sa, 0);
            chk("rstmid_kx", obs_kx, 0);
            chk("rstmid_ov", obs_ov, 0);
            @(posedge clk); #1;
        end
        rst = 0; in_valid = 0; key_valid = 0; out_ready = 0;
        @(negedge clk);
        chk("rstmid_busy", obs_busy, 0);
        chk("rstmid_idx", obs_idx, 0);
        chk("rstmid_stall", obs_stall, 0);
        @(posedge clk); #1;

        // NR=14 single block.
        tb_sel = 1;
        kv_q.delete();
        run_block(1, done_c, n_sa, n_kx, st);
        chk("nr14_done", done_c, 16);
        chk("nr14_sa", n_sa, 15);
        chk("nr14_kx", n_kx, 14);
        chk("nr14_stall", st, 0);
        sync_idle();

        // 300-cycle key stall: counter saturates.
        tb_sel = 0;
        kv_q.delete();
        kv_q.push_back(1); kv_q.push_back(1);
        for (int i = 0; i < 300; i++) kv_q.push_back(0);
        run_block(1, done_c, n_sa, n_kx, st);
        model(10, exp_done, exp_st);
        chk("sat_done", done_c, exp_done);
        chk("sat_stall", st, exp_st);
        chk("sat_stall_const", st, 255);
        sync_idle();

        // Random key availability and consumer delay on both instances.
        for (int k = 0; k < 10; k++) begin
            tb_sel = $urandom_range(0, 1);
            nr     = tb_sel ? 14 : 10;
            p      = $urandom_range(30, 100);
            dly    = $urandom_range(1, 4);
            kv_q.delete();
            for (int i = 0; i < 60; i++) kv_q.push_back($urandom_range(1, 100) <= p);
            model(nr, exp_done, exp_st);
            run_block(dly, done_c, n_sa, n_kx, st);
            chk($sformatf("rnd%0d_done", k), done_c, exp_done);
            chk($sformatf("rnd%0d_stall", k), st, exp_st);
            chk($sformatf("rnd%0d_sa", k), n_sa, nr + 1);
            chk($sformatf("rnd%0d_kx", k), n_kx, nr);
            sync_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
